mod_99_vr_tx: RTL and testbench

MOD_99_VR_TX -- requirements
Module: mod_99_vr_tx

---
 rtl/mod_99_vr_tx.sv | 171 +++++++++++++++++
 tb/tb_mod_99_vr_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_99_vr_tx.sv
// Verify/respond mPacket transmitter: preamble, SMD, zero-filled payload, CRC-32 FCS, then inter-packet gap.
// Outputs are decoded from registered state, so the first preamble octet appears the cycle after the start edge.
module mod_99_vr_tx #(
    parameter int IPG_LEN  = 12,
    parameter int DATA_LEN = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_v,
    input  logic       send_r,
    input  logic       tx_busy,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       send_v_clr,
    output logic       send_r_clr,
    output logic       vr_active
);

    localparam int PRE_LEN = 7;
    localparam int FCS_LEN = 4;
    localparam int MAX_A   = (DATA_LEN > IPG_LEN) ? DATA_LEN : IPG_LEN;
    localparam int MAX_LEN = (MAX_A > 8) ? MAX_A : 8;
    localparam int CW      = $clog2(MAX_LEN);

    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_LEN - 1);
    localparam logic [CW-1:0] FCS_LAST  = CW'(FCS_LEN - 1);
    localparam logic [CW-1:0] IPG_LAST  = CW'(IPG_LEN - 1);

    localparam logic [7:0]  PRE_OCTET     = 8'h55;
    localparam logic [7:0]  SMD_VERIFY    = 8'h07;
    localparam logic [7:0]  SMD_RESPOND   = 8'h19;
    localparam logic [7:0]  DATA_OCTET    = 8'h00;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SMD,
        ST_DATA,
        ST_FCS,
        ST_IPG
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   crc_reg, crc_next;
    logic          resp_reg, resp_next;
    logic          start_req;
    logic [7:0]    fcs_octet [FCS_LEN];

    // Reflected CRC-32, one octet per cycle, LSB of the octet first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] octet);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ octet[i]) begin
                c = (c >> 1) ^ CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < FCS_LEN; gi++) begin : g_fcs
            assign fcs_octet[gi] = ~crc_reg[8*gi +: 8];
        end
    endgenerate

    assign start_req = (send_v | send_r) & ~tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            crc_reg   <= CRC_INIT;
            resp_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            crc_reg   <= crc_next;
            resp_reg  <= resp_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        crc_next   = crc_reg;
        resp_next  = resp_reg;
        txd        = 8'h00;
        tx_en      = 1'b0;
        send_v_clr = 1'b0;
        send_r_clr = 1'b0;
        vr_active  = (state_reg != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                if (start_req) begin
                    state_next = ST_PREAMBLE;
                    cnt_next   = '0;
                    resp_next  = send_r;
                end
            end
            ST_PREAMBLE: begin
                txd   = PRE_OCTET;
                tx_en = 1'b1;
                if (cnt_reg == PRE_LAST) begin
                    state_next = ST_SMD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_SMD: begin
                txd        = resp_reg ? SMD_RESPOND : SMD_VERIFY;
                tx_en      = 1'b1;
                crc_next   = CRC_INIT;
                state_next = ST_DATA;
                cnt_next   = '0;
            end
            ST_DATA: begin
                txd      = DATA_OCTET;
                tx_en    = 1'b1;
                crc_next = crc_byte(crc_reg, DATA_OCTET);
                if (cnt_reg == DATA_LAST) begin
                    state_next = ST_FCS;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_FCS: begin
                txd   = fcs_octet[cnt_reg[1:0]];
                tx_en = 1'b1;
                if (cnt_reg == FCS_LAST) begin
                    // Requester drops its flag on this pulse, before the gap begins.
                    send_v_clr = ~resp_reg;
                    send_r_clr = resp_reg;
                    state_next = ST_IPG;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_IPG: begin
                if (cnt_reg == IPG_LAST) begin
                    // Leaving the gap doubles as the idle exit, so a pending request loses no cycle.
                    cnt_next = '0;
                    if (start_req) begin
                        state_next = ST_PREAMBLE;
                        resp_next  = send_r;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mod_99_vr_tx.sv
// Bench for mod_99_vr_tx: start-up vector table, directed corner sequences and random requests
// checked cycle by cycle against a frame/gap timeline model.
module tb_mod_99_vr_tx;

    localparam int IPG   = 12;
    localparam int DLEN  = 60;
    localparam int FRAME = 8 + DLEN + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send_v = 1'b0, send_r = 1'b0, tx_busy = 1'b0;
    logic [7:0] txd;
    logic       tx_en, send_v_clr, send_r_clr, vr_active;

    logic       send_v4 = 1'b0, send_r4 = 1'b0, tx_busy4 = 1'b0;
    logic [7:0] txd4;
    logic       tx_en4, send_v_clr4, send_r_clr4, vr_active4;

    mod_99_vr_tx #(.IPG_LEN(IPG), .DATA_LEN(DLEN)) dut (
        .clk(clk), .rst_n(rst_n), .send_v(send_v), .send_r(send_r), .tx_busy(tx_busy),
        .txd(txd), .tx_en(tx_en), .send_v_clr(send_v_clr), .send_r_clr(send_r_clr),
        .vr_active(vr_active)
    );

    mod_99_vr_tx #(.IPG_LEN(4), .DATA_LEN(DLEN)) dut4 (
        .clk(clk), .rst_n(rst_n), .send_v(send_v4), .send_r(send_r4), .tx_busy(tx_busy4),
        .txd(txd4), .tx_en(tx_en4), .send_v_clr(send_v_clr4), .send_r_clr(send_r_clr4),
        .vr_active(vr_active4)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         pos = -1;
    bit         resp = 1'b0;
    bit         auto_clear = 1'b1;
    logic [7:0] frame_v [FRAME];
    logic [7:0] frame_r [FRAME];

    typedef struct {
        logic       sv, sr, busy;
        logic       en;
        logic [7:0] d;
        logic       act;
    } vec_t;
    vec_t tbl [12];

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // Textbook MSB-first CRC-32 on bit-reversed octets; the reflected FCS is its mirror image.
    function automatic logic [31:0] fcs_of_zeros(input int n);
        logic [31:0] c;
        logic [7:0]  b;
        logic [7:0]  rb;
        c = 32'hFFFF_FFFF;
        b = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) rb[k] = b[7-k];
            c = c ^ {rb, 24'h0};
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
        end
        return ~rev32(c);
    endfunction

    task automatic build_frames();
        logic [31:0] fcs;
        fcs = fcs_of_zeros(DLEN);
        for (int i = 0; i < FRAME; i++) begin
            if (i < 7)                frame_v[i] = 8'h55;
            else if (i == 7)          frame_v[i] = 8'h07;
            else if (i < 8 + DLEN)    frame_v[i] = 8'h00;
            else                      frame_v[i] = fcs[8*(i-8-DLEN) +: 8];
            frame_r[i] = (i == 7) ? 8'h19 : frame_v[i];
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: predict the timeline position from the inputs seen at the edge, then compare.
    task automatic step();
        int         pos_n;
        bit         resp_n;
        logic       e_en, e_act, e_vc, e_rc;
        logic [7:0] e_txd;
        pos_n  = pos + 1;
        resp_n = resp;
        if (pos < 0 || pos == FRAME + IPG - 1) begin
            if ((send_v || send_r) && !tx_busy) begin
                pos_n  = 0;
                resp_n = send_r;
            end else begin
                pos_n = -1;
            end
        end
        @(posedge clk);
        #1;
        pos   = pos_n;
        resp  = resp_n;
        e_en  = (pos >= 0) && (pos < FRAME);
        e_txd = e_en ? (resp ? frame_r[pos] : frame_v[pos]) : 8'h00;
        e_act = (pos >= 0);
        e_vc  = (pos == FRAME - 1) && !resp;
        e_rc  = (pos == FRAME - 1) && resp;
        checks++;
        if ({tx_en, txd, vr_active, send_v_clr, send_r_clr} !== {e_en, e_txd, e_act, e_vc, e_rc}) begin
            errors++;
            $display("FAIL cycle pos=%0d resp=%0d: got en=%b txd=%h act=%b vclr=%b rclr=%b, expected en=%b txd=%h act=%b vclr=%b rclr=%b",
                     pos, resp, tx_en, txd, vr_active, send_v_clr, send_r_clr, e_en, e_txd, e_act, e_vc, e_rc);
        end
        if (auto_clear) begin
            if (send_v_clr) send_v = 1'b0;
            if (send_r_clr) send_r = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("async_reset", {23'd0, tx_en, txd, vr_active},
              {23'd0, 1'b0, 8'h00, 1'b0});
        check("reset_clr", {30'd0, send_v_clr, send_r_clr}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pos = -1;
    endtask

    initial begin
        int         len1, gap, len2, idx, smd1, smd2;
        logic       en_hist [200];
        logic [7:0] d_hist  [200];

        build_frames();
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h19, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            send_v  = tbl[i].sv;
            send_r  = tbl[i].sr;
            tx_busy = tbl[i].busy;
            @(posedge clk);
            #1;
            checks++;
            if ({tx_en, txd, vr_active, send_v_clr, send_r_clr} !== {tbl[i].en, tbl[i].d, tbl[i].act, 2'b00}) begin
                errors++;
                $display("FAIL vec%0d: got en=%b txd=%h act=%b clr=%b%b, expected en=%b txd=%h act=%b clr=00",
                         i, tx_en, txd, vr_active, send_v_clr, send_r_clr, tbl[i].en, tbl[i].d, tbl[i].act);
            end
        end
        send_v = 1'b0; send_r = 1'b0; tx_busy = 1'b0;
        do_reset();

        // Single verify frame followed by its gap.
        send_v = 1'b1;
        repeat (FRAME + IPG + 4) step();

        // Both requests together: respond frame first, verify right after the gap.
        send_v = 1'b1; send_r = 1'b1;
        repeat (2 * (FRAME + IPG) + 4) step();

        // Blocked by tx_busy for 20 cycles.
        send_r = 1'b1; tx_busy = 1'b1;
        repeat (20) step();
        tx_busy = 1'b0;
        repeat (FRAME + IPG + 4) step();

        // tx_busy raised and request dropped mid-frame.
        send_v = 1'b1;
        for (int i = 0; i < 20 && pos != 29; i++) step();
        tx_busy = 1'b1; send_v = 1'b0;
        repeat (FRAME + IPG) step();
        tx_busy = 1'b0;
        repeat (4) step();

        // Reset at octet 40, then a fresh frame from the still-held request.
        send_v = 1'b1;
        for (int i = 0; i < 60 && pos != 39; i++) step();
        do_reset();
        repeat (FRAME + IPG + 4) step();

        // Random requests, busy toggling and early drops.
        for (int i = 0; i < 3000; i++) begin
            if (!send_v && $urandom_range(0, 39) == 0) send_v = 1'b1;
            if (!send_r && $urandom_range(0, 39) == 0) send_r = 1'b1;
            if (send_v && $urandom_range(0, 199) == 0) send_v = 1'b0;
            if ($urandom_range(0, 7) == 0) tx_busy = ~tx_busy;
            step();
        end

        // Short-gap build: back-to-back frames separated by exactly 4 idle octets.
        send_v4 = 1'b1; send_r4 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            en_hist[i] = tx_en4;
            d_hist[i]  = txd4;
            if (send_v_clr4) send_v4 = 1'b0;
            if (send_r_clr4) send_r4 = 1'b0;
        end
        idx = 0; len1 = 0; gap = 0; len2 = 0; smd1 = -1; smd2 = -1;
        while (idx < 200 && !en_hist[idx]) idx++;
        if (idx + 7 < 200) smd1 = d_hist[idx + 7];
        while (idx < 200 && en_hist[idx]) begin len1++; idx++; end
        while (idx < 200 && !en_hist[idx]) begin gap++; idx++; end
        if (idx + 7 < 200) smd2 = d_hist[idx + 7];
        while (idx < 200 && en_hist[idx]) begin len2++; idx++; end
        check("ipg4_len1", len1, FRAME);
        check("ipg4_gap", gap, 4);
        check("ipg4_len2", len2, FRAME);
        check("ipg4_smd1", smd1, 32'h19);
        check("ipg4_smd2", smd2, 32'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
